// File: rtl/uart_tx_core.sv
// uart_tx_core: 8-bit UART transmitter, start/8 data LSB-first/stop.
// Optional even parity bit after the data when UART_TX_PARITY_EN is defined.
module uart_tx_core #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [7:0]       tx_data,
    input  logic [DIV_W-1:0] baud_divisor,
    output logic             tx_serial,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             baud_tick
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n, cnt_inc;
    logic [DIV_W-1:0] nm1, nm1_n, nm1_acc;
    logic [7:0]       sh, sh_n;
    logic [2:0]       idx, idx_n;
    logic             serial_n, busy_n, done_n, tick_n;
    logic             last;
`ifdef UART_TX_PARITY_EN
    logic             par, par_n;
`endif

    // nm1 holds the bit period minus one, so the counter never needs N itself
    assign nm1_acc = (baud_divisor > DIV_W'(1)) ? baud_divisor - DIV_W'(1) : '0;
    assign cnt_inc = cnt + DIV_W'(1);
    assign last    = (cnt == nm1);

    // next-state and registered-output values
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        nm1_n    = nm1;
        sh_n     = sh;
        idx_n    = idx;
        serial_n = tx_serial;
        busy_n   = tx_busy;
        done_n   = 1'b0;
        tick_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n    = par;
`endif
        if (state != IDLE) begin
            if (last) begin
                cnt_n  = '0;
                tick_n = (nm1 == '0);
            end else begin
                cnt_n  = cnt_inc;
                tick_n = (cnt_inc == nm1);
            end
        end
        unique case (state)
            IDLE: begin
                if (tx_start) begin
                    state_n  = START;
                    cnt_n    = '0;
                    nm1_n    = nm1_acc;
                    sh_n     = tx_data;
                    serial_n = 1'b0;
                    busy_n   = 1'b1;
                    tick_n   = (nm1_acc == '0);
`ifdef UART_TX_PARITY_EN
                    par_n    = ^tx_data;
`endif
                end
            end
            START: begin
                if (last) begin
                    state_n  = DATA;
                    idx_n    = '0;
                    serial_n = sh[0];
                    sh_n     = {1'b0, sh[7:1]};
                end
            end
            DATA: begin
                if (last) begin
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n  = PARITY;
                        serial_n = par;
`else
                        state_n  = STOP;
                        serial_n = 1'b1;
`endif
                    end else begin
                        idx_n    = idx + 3'd1;
                        serial_n = sh[0];
                        sh_n     = {1'b0, sh[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last) begin
                    state_n  = STOP;
                    serial_n = 1'b1;
                end
            end
`endif
            STOP: begin
                if (last) begin
                    state_n  = IDLE;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    tick_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            nm1       <= '0;
            sh        <= '0;
            idx       <= '0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            baud_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            nm1       <= nm1_n;
            sh        <= sh_n;
            idx       <= idx_n;
            tx_serial <= serial_n;
            tx_busy   <= busy_n;
            tx_done   <= done_n;
            baud_tick <= tick_n;
`ifdef UART_TX_PARITY_EN
            par       <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: randomized self-checking bench for uart_tx_core.
// Expected line levels come from a frame-bit model, not from the RTL.
module tb_uart_tx_core;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [31:0] baud_divisor;
    logic        tx_serial;
    logic        tx_busy;
    logic        tx_done;
    logic        baud_tick;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_core #(.DIV_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .baud_divisor (baud_divisor),
        .tx_serial    (tx_serial),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .baud_tick    (baud_tick)
    );

    // level of frame bit i: start, 8 data LSB first, optional even parity, stop
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (FB == 11 && i == 9) return ^d;
        return 1'b1;
    endfunction

    // Sends one frame; entered at a negedge while idle or in a done cycle.
    // With noise, inputs are scrambled mid-frame and must have no effect.
    task automatic test_frame(input logic [7:0] d, input int unsigned div,
                              input bit noise, input string name);
        int unsigned n;
        int unsigned f;
        logic [3:0]  got;
        logic [3:0]  exp;
        n = (div <= 1) ? 1 : div;
        f = FB * n;
        tx_data      = d;
        baud_divisor = div;
        tx_start     = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int unsigned k = 1; k <= f; k++) begin
            got = {tx_serial, tx_busy, tx_done, baud_tick};
            exp = {exp_bit(d, int'((k - 1) / n)), 1'b1, 1'b0, (k % n) == 0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s cyc=%0d {ser,busy,done,tick} got=%b exp=%b",
                         name, k, got, exp);
            end
            if (noise) begin
                tx_start     = ($urandom_range(0, 3) == 0);
                tx_data      = 8'($urandom);
                baud_divisor = $urandom_range(0, 9);
            end
            @(negedge clk);
        end
        tx_start = 1'b0;
        got = {tx_serial, tx_busy, tx_done, baud_tick};
        checks++;
        if (got !== 4'b1010) begin
            failures++;
            $display("FAIL %s_done {ser,busy,done,tick} got=%b exp=1010",
                     name, got);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        tx_start     = 1'b1;
        tx_data      = 8'h55;
        baud_divisor = 32'd2;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_serial, tx_busy, tx_done, baud_tick} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=1000",
                     {tx_serial, tx_busy, tx_done, baud_tick});
        end
        rst      = 1'b0;
        tx_start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_serial, tx_busy, tx_done, baud_tick} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_priority got=%b exp=1000",
                     {tx_serial, tx_busy, tx_done, baud_tick});
        end
    endtask

    task automatic test_directed();
        test_frame(8'hA5, 4, 1'b0, "a5_div4");
        @(negedge clk);
        test_frame(8'h07, 4, 1'b0, "07_div4");
        @(negedge clk);
        test_frame(8'hFF, 0, 1'b0, "ff_div0");
        @(negedge clk);
        test_frame(8'h3C, 1, 1'b0, "3c_div1");
        @(negedge clk);
    endtask

    task automatic test_ignore_and_change();
        test_frame(8'hC3, 4, 1'b1, "noise_div4");
        test_frame(8'h96, 8, 1'b0, "next_div8");
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            test_frame(8'($urandom), $urandom_range(0, 7), 1'b1, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        test_frame(8'h81, 3, 1'b0, "b2b_first");
        test_frame(8'h7E, 2, 1'b0, "b2b_second");
        test_frame(8'h00, 0, 1'b0, "b2b_third");
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [3:0] got;
        logic [3:0] exp;
        tx_data      = 8'hA5;
        baud_divisor = 32'd4;
        tx_start     = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            got = {tx_serial, tx_busy, tx_done, baud_tick};
            exp = {exp_bit(8'hA5, (k - 1) / 4), 1'b1, 1'b0, (k % 4) == 0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rstmid_pre cyc=%0d got=%b exp=%b", k, got, exp);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            got = {tx_serial, tx_busy, tx_done, baud_tick};
            checks++;
            if (got !== 4'b1000) begin
                failures++;
                $display("FAIL rstmid_abort cyc=%0d got=%b exp=1000", k, got);
            end
            @(negedge clk);
        end
        test_frame(8'h5A, 3, 1'b0, "after_rst");
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        tx_start     = 1'b0;
        tx_data      = 8'h00;
        baud_divisor = 32'd0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_ignore_and_change();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter DIV_W, default 32: width of baud_divisor and the internal bit-period counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 tx_start  input  1  frame request; accepted only in a cycle where tx_busy=0.
REQ-005 tx_data  input  8  byte to send; sampled in the accept cycle.
REQ-006 baud_divisor  input  DIV_W  clocks per bit; sampled in the accept cycle.
REQ-007 tx_serial  output  1  serial line; idle high.
REQ-008 tx_busy  output  1  high while a frame is on the line.
REQ-009 tx_done  output  1  one-cycle pulse at frame completion.
REQ-010 baud_tick  output  1  one-cycle pulse in the last cycle of every bit period.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, (PARITY), STOP; all outputs registered.
REQ-012 Accept: in IDLE with tx_start=1 -> latch tx_data and baud_divisor, go to START at the next edge.
REQ-013 Bit period N = latched baud_divisor; divisor 0 or 1 SHALL give N=1.
REQ-014 Accept in cycle c -> tx_serial=0 and tx_busy=1 from cycle c+1; every bit lasts exactly N cycles.
REQ-015 DATA SHALL send 8 bits LSB first, using a 3-bit index that advances on baud_tick.
REQ-016 STOP SHALL drive tx_serial=1 for N cycles.
REQ-017 Frame = 10N cycles (c+1..c+10N); in cycle c+10N+1, tx_done=1, tx_busy=0, state=IDLE.
REQ-018 tx_start while tx_busy=1 SHALL be ignored, not queued.
REQ-019 tx_start in the tx_done cycle SHALL be accepted: one idle-high cycle between frames, no more.
REQ-020 Changes to tx_data or baud_divisor after accept SHALL NOT affect the frame in flight.
REQ-021 The bit counter SHALL count 0..N-1 and wrap to 0 with a baud_tick pulse; no overflow at N=2^DIV_W-1.
REQ-022 baud_tick SHALL stay 0 in IDLE.

Reset
REQ-023 rst=1 at any edge -> state IDLE, tx_serial=1, tx_busy=0, tx_done=0, baud_tick=0, counters and latches cleared.
REQ-024 Reset mid-frame SHALL abort the frame without a tx_done pulse; tx_serial=1 from the next cycle.
REQ-025 rst SHALL take priority over a simultaneous tx_start.

Configuration
REQ-026 With UART_TX_PARITY_EN defined, a PARITY state of N cycles SHALL follow DATA, sending even parity (XOR of the 8 data bits); frame = 11N cycles and tx_done moves to c+11N+1.
REQ-027 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; frame = 10N cycles.

Verification
REQ-028 divisor=4, tx_data=0xA5 -> tx_serial reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_done pulses at cycle c+41.
REQ-029 With UART_TX_PARITY_EN, divisor=4, 0xA5 -> parity bit 0 in cycles c+37..c+40; for 0x07 -> parity bit 1; tx_done at c+45.
REQ-030 divisor=0, tx_data=0xFF -> 10-cycle frame 0,1,1,1,1,1,1,1,1,1; baud_tick high every cycle of the frame.
REQ-031 tx_start pulsed mid-frame with 0x00 -> ignored, first frame unchanged; tx_start held through the tx_done cycle -> second frame starts with exactly one idle-high cycle between frames.
REQ-032 rst asserted during DATA bit 3 -> next cycle tx_serial=1, tx_busy=0; no tx_done pulse; a new frame then sends correctly.
REQ-033 baud_divisor changed 4->8 mid-frame -> current frame stays at 4 cycles per bit; the next frame uses 8.
